// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller port between VGA (0), UART (1),
// Milestone 1 (2) and Milestone 2 (3). VGA has absolute priority; 1..3
// rotate round-robin with bursts bounded by MAX_BURST while others wait.
// Read data is routed back through a READ_LATENCY-deep tag pipe.
// Optional macro SRAM_ARB_STATS_EN adds Grant_count / Switch_count outputs.
module sram_arbiter #(
  parameter int MAX_BURST    = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  Req,
  input  logic [3:0]  Req_we_n,
  input  logic [71:0] Req_address,
  input  logic [63:0] Req_write_data,
  output logic [3:0]  Grant,
  output logic [3:0]  Read_valid,
  output logic [15:0] Read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [63:0] Grant_count,
  output logic [15:0] Switch_count
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_OWN    = 2'd1;
  localparam logic [1:0] S_SWITCH = 2'd2;

  localparam int BW = $clog2(MAX_BURST);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [3:0]    grant_q, grant_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;

  logic          issue;
  logic          owner_we_n;
  logic          others_waiting;
  logic          leave;
  logic [1:0]    win_id;
  logic [1:0]    cand;
  logic          found;

  logic [READ_LATENCY-1:0]   pipe_valid_q, pipe_valid_d;
  logic [2*READ_LATENCY-1:0] pipe_id_q, pipe_id_d;
  logic [1:0]                tail_id;

  genvar gi;

  // An access happens only when the granted requester is still asking.
  assign issue          = |(grant_q & Req);
  assign owner_we_n     = Req_we_n[owner_q];
  assign others_waiting = |(Req & ~grant_q);
  assign Grant          = grant_q;
  assign Read_data      = SRAM_read_data;

  // Winner: VGA first, otherwise the first requester after rr_ptr over 1..3.
  always_comb begin
    win_id = 2'd0;
    found  = Req[0];
    cand   = rr_ptr_q;
    for (int k = 0; k < 3; k++) begin
      cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
      if (!found && Req[cand]) begin
        win_id = cand;
        found  = 1'b1;
      end
    end
  end

  // Conditions that end the current ownership at the end of this cycle.
  always_comb begin
    leave = !Req[owner_q]
         || (Req[0] && owner_q != 2'd0)
         || (owner_q != 2'd0 && others_waiting && burst_cnt_q == BURST_LAST);
  end

  // Ownership FSM: idle -> own -> one-cycle bubble -> next owner or idle.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      S_IDLE, S_SWITCH: begin
        if (|Req) begin
          state_d     = S_OWN;
          owner_d     = win_id;
          grant_d     = 4'(4'b0001 << win_id);
          burst_cnt_d = '0;
          if (win_id != 2'd0) rr_ptr_d = win_id;
        end else begin
          state_d = S_IDLE;
          grant_d = 4'b0000;
        end
      end
      S_OWN: begin
        if (leave) begin
          state_d     = S_SWITCH;
          grant_d     = 4'b0000;
          burst_cnt_d = '0;
        end else if (burst_cnt_q != BURST_LAST) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  // FSM and arbitration registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 2'd0;
      grant_q     <= 4'b0000;
      burst_cnt_q <= '0;
      rr_ptr_q    <= 2'd3;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // SRAM port mux: the issuing owner drives it, otherwise an idle read of 0.
  always_comb begin
    SRAM_address    = 18'd0;
    SRAM_write_data = 16'd0;
    SRAM_we_n       = 1'b1;
    if (issue) begin
      SRAM_address    = Req_address[18*owner_q +: 18];
      SRAM_write_data = Req_write_data[16*owner_q +: 16];
      SRAM_we_n       = owner_we_n;
    end
  end

  // Tag pipe: stage 0 takes this cycle's read, later stages shift along.
  assign pipe_valid_d[0]  = issue & owner_we_n;
  assign pipe_id_d[1:0]   = owner_q;
  generate
    for (gi = 1; gi < READ_LATENCY; gi++) begin : g_tag
      assign pipe_valid_d[gi]        = pipe_valid_q[gi-1];
      assign pipe_id_d[2*gi +: 2]    = pipe_id_q[2*(gi-1) +: 2];
    end
  endgenerate

  // Tag pipe registers; reset drops every read still in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pipe_valid_q <= '0;
      pipe_id_q    <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_id_q    <= pipe_id_d;
    end
  end

  assign tail_id = pipe_id_q[2*(READ_LATENCY-1) +: 2];

  // Flag the requester whose read data is on SRAM_read_data this cycle.
  always_comb begin
    Read_valid = 4'b0000;
    if (pipe_valid_q[READ_LATENCY-1]) Read_valid[tail_id] = 1'b1;
  end

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] switch_count_q, switch_count_d;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_stat
      logic [15:0] cnt_q, cnt_d;

      // Saturating count of accesses issued by requester gi.
      always_comb begin
        cnt_d = cnt_q;
        if (issue && owner_q == 2'(gi) && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end

      // Per-requester counter register.
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) cnt_q <= 16'd0;
        else       cnt_q <= cnt_d;
      end

      assign Grant_count[16*gi +: 16] = cnt_q;
    end
  endgenerate

  // Saturating count of bubble cycles.
  always_comb begin
    switch_count_d = switch_count_q;
    if (state_q == S_SWITCH && switch_count_q != 16'hFFFF) switch_count_d = switch_count_q + 16'd1;
  end

  // Bubble counter register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) switch_count_q <= 16'd0;
    else       switch_count_q <= switch_count_d;
  end

  assign Switch_count = switch_count_q;
`endif

endmodule
